// File: rtl/vram_arb.sv
// vram_arb: one CPU port and NUM_RD video read channels share a single-port VRAM through a registered arbiter.
// Latency is 2 cycles from grant to ack; requesters hold req until ack, and CPU_MAX_WAIT bounds CPU starvation.
module vram_arb #(
  parameter int ADDR_WIDTH   = 14,
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_RD       = 2,
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         cpu_req,
  input  logic [ADDR_WIDTH-1:0]        cpu_addr,
  input  logic                         cpu_wren,
  input  logic [DATA_WIDTH-1:0]        cpu_wrdata,
  input  logic [DATA_WIDTH-1:0]        cpu_wrmask,
  output logic                         cpu_ack,
  output logic [DATA_WIDTH-1:0]        cpu_rddata,
  input  logic [NUM_RD-1:0]            vid_req,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] vid_addr,
  output logic [NUM_RD-1:0]            vid_ack,
  output logic [NUM_RD*DATA_WIDTH-1:0] vid_rddata
);
  localparam int WW = (CPU_MAX_WAIT > 0) ? $clog2(CPU_MAX_WAIT + 1) : 1;
  localparam logic [WW-1:0] WAIT_MAX = WW'(CPU_MAX_WAIT);

  typedef enum logic {ARB, RMW} state_t;
  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_q;
  logic [WW-1:0]         wait_cnt;
  logic                  cpu_pend, cpu_elig, gnt_cpu, s1_cpu, force_cpu, cpu_masked;
  logic [NUM_RD-1:0]     vid_pend, vid_elig, gnt_vid, s1_vid;
  logic [ADDR_WIDTH-1:0] rmw_addr, mem_addr;
  logic [DATA_WIDTH-1:0] rmw_data, rmw_mask, mem_wdata;
  logic                  mem_we;

  assign cpu_elig   = cpu_req & ~cpu_pend;
  assign vid_elig   = vid_req & ~vid_pend;
  assign force_cpu  = cpu_elig && (wait_cnt == WAIT_MAX);
  assign cpu_masked = cpu_wren && (cpu_wrmask != '1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ARB;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (gnt_cpu && cpu_masked) state_nxt = RMW;
      RMW:     state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // Grants are only issued in ARB; the RMW cycle owns the memory port for its write.
  always_comb begin
    gnt_cpu = 1'b0;
    gnt_vid = '0;
    if (state == ARB) begin
      if (force_cpu)            gnt_cpu = 1'b1;
      else if (vid_elig != '0)  gnt_vid = vid_elig & (~vid_elig + NUM_RD'(1));
      else                      gnt_cpu = cpu_elig;
    end
  end

  always_comb begin
    mem_addr  = cpu_addr;
    mem_we    = 1'b0;
    mem_wdata = cpu_wrdata;
    if (state == RMW) begin
      mem_addr  = rmw_addr;
      mem_we    = 1'b1;
      mem_wdata = (rd_q & ~rmw_mask) | (rmw_data & rmw_mask);
    end else if (gnt_cpu) begin
      mem_we = cpu_wren && !cpu_masked;
    end else begin
      for (int i = 0; i < NUM_RD; i++)
        if (gnt_vid[i]) mem_addr = vid_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Read-first: rd_q captures the old word even when the same cycle writes.
  always_ff @(posedge clk) begin
    rd_q <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt   <= '0;
      cpu_pend   <= 1'b0;
      vid_pend   <= '0;
      s1_cpu     <= 1'b0;
      s1_vid     <= '0;
      cpu_ack    <= 1'b0;
      vid_ack    <= '0;
      cpu_rddata <= '0;
      vid_rddata <= '0;
      rmw_addr   <= '0;
      rmw_data   <= '0;
      rmw_mask   <= '0;
    end else begin
      if (gnt_cpu)
        wait_cnt <= '0;
      else if (state == ARB && cpu_elig && wait_cnt != WAIT_MAX)
        wait_cnt <= wait_cnt + WW'(1);
      cpu_pend <= gnt_cpu | (cpu_pend & ~cpu_ack);
      vid_pend <= gnt_vid | (vid_pend & ~vid_ack);
      s1_cpu   <= gnt_cpu;
      s1_vid   <= gnt_vid;
      cpu_ack  <= s1_cpu;
      vid_ack  <= s1_vid;
      if (s1_cpu) cpu_rddata <= rd_q;
      for (int i = 0; i < NUM_RD; i++)
        if (s1_vid[i]) vid_rddata[i*DATA_WIDTH +: DATA_WIDTH] <= rd_q;
      if (gnt_cpu) begin
        rmw_addr <= cpu_addr;
        rmw_data <= cpu_wrdata;
        rmw_mask <= cpu_wrmask;
      end
    end
  end
endmodule
